mem_apb_master: RTL
===================

MEM_APB_MASTER -- requirements
Module: mem_apb_master

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 8, data bus width.
- DEPTH, 32, number of addressable slave registers.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 16, maximum ACCESS cycles waited for ready; must be >= 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-low reset.
- cmd_valid, input, 1, command request present.
- cmd_ready, output, 1, block can accept a command.
- cmd_wr, input, 1, 1 = write, 0 = read.
- cmd_addr, input, ADDR_WIDTH, target address.
- cmd_wdata, input, DATA_WIDTH, write data.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, DATA_WIDTH, read data; 0 for writes and errors.
- rsp_err, output, 1, transfer timed out.
- sel, output, 1, slave select.
- enable, output, 1, access-phase enable.
- wr, output, 1, write strobe to the slave.
- addr, output, ADDR_WIDTH, slave address.
- wdata, output, DATA_WIDTH, slave write data.
- ready, input, 1, slave ready.
- rdata, input, DATA_WIDTH, slave read data; valid while ready and enable are high.

REQ-003 Reset SHALL be synchronous and active-low, and clk SHALL be the only clock.

Function
REQ-004 The block SHALL implement four states: IDLE, SETUP, ACCESS and RESP.

REQ-005 cmd_ready SHALL be 1 only in IDLE with reset high. A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.

REQ-006 On acceptance, the block SHALL register cmd_wr, cmd_addr and cmd_wdata onto wr, addr and wdata, and SHALL go to SETUP. These outputs SHALL hold stable until the next acceptance.

REQ-007 SETUP SHALL last exactly one cycle with sel=1 and enable=0, then go to ACCESS.

REQ-008 In ACCESS, sel and enable SHALL both be 1.

REQ-009 In ACCESS, on the first edge with ready=1:
- the block SHALL capture rdata into rsp_rdata when wr=0, and load 0 when wr=1;
- rsp_err SHALL be set to 0;
- the block SHALL go to RESP.

REQ-010 A 16-bit-or-narrower wait counter ($clog2(TIMEOUT+1) bits) SHALL clear on entering ACCESS and increment on each ACCESS cycle with ready=0. If it reaches TIMEOUT, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0.

REQ-011 In RESP:
- sel=0 and enable=0;
- rsp_valid=1;
- rsp_rdata and rsp_err SHALL be held until an edge with rsp_ready=1, then the block SHALL return to IDLE.

REQ-012 rsp_valid SHALL be 0 in every state except RESP. sel and enable SHALL be 0 in IDLE and RESP.

REQ-013 With a zero-wait slave and rsp_ready held at 1, timing SHALL be:
- rsp_valid asserts 3 cycles after the acceptance edge;
- back-to-back commands repeat every 4 cycles.

REQ-014 A command presented while cmd_ready=0 SHALL NOT be accepted or modified. The upstream holds it until accepted.

REQ-015 A ready=1 seen in IDLE, SETUP or RESP SHALL be ignored.

REQ-016 If ready=1 and the counter reaches TIMEOUT on the same edge, ready SHALL take priority and the response SHALL be a success.

REQ-017 All outputs except cmd_ready SHALL be driven directly from flip-flops.

Reset
REQ-018 On an edge with reset=0, the block SHALL:
- go to IDLE;
- clear sel, enable, wr, addr, wdata, rsp_valid, rsp_err, rsp_rdata and the wait counter to 0;
- drive cmd_ready to 0 while reset=0 and to 1 on the first cycle after release.

REQ-019 A reset asserted during SETUP, ACCESS or RESP SHALL abandon the transfer with no response. sel and enable SHALL be low after that edge.

Verification
REQ-020 Bench scenarios:
- Write then read, zero-wait mem_block slave: write addr 5 data 0xA5, then read addr 5 -> rsp_rdata=0xA5, rsp_err=0, rsp_valid 3 cycles after each acceptance.
- Setup/access sequencing: one command -> exactly one cycle of sel=1,enable=0 followed by sel=1,enable=1; sel=0 in RESP.
- Timeout: slave holds ready=0, TIMEOUT=16 -> rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles, then return to IDLE.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset mid-ACCESS: reset=0 for one edge during a stalled read -> all outputs 0 next cycle, no rsp_valid, cmd_ready=1 after release.
- Streaming: 8 back-to-back writes to addrs 0..7 with rsp_ready=1 -> one acceptance every 4 cycles, slave memory holds all 8 values.

Source files
------------

// File: rtl/mem_apb_master_if.sv
// Command, response and APB-style slave bus signals for mem_apb_master.
// The master modport is the DUT side; the slave modport is the environment/slave side.
interface mem_apb_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  sel;
  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, wr, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, wr, addr, wdata
  );
endinterface

// File: rtl/mem_apb_master.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP,
// with a bounded wait on slave ready and a held response until consumed.
module mem_apb_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_apb_master_if.master     bus
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  enable_q, enable_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state and registered-output decode; bus strobes follow the next state
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_SETUP;
          wr_d    = bus.cmd_wr;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_ACCESS: begin
        // ready wins over a timeout landing on the same edge
        if (bus.ready) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? {DATA_WIDTH{1'b0}} : bus.rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d     = S_RESP;
          cnt_d       = cnt_inc;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    sel_d       = (state_d == S_SETUP) || (state_d == S_ACCESS);
    enable_d    = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      enable_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && reset;
  assign bus.sel       = sel_q;
  assign bus.enable    = enable_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
